// File: rtl/common_pkg.sv
// Shared types and sizes for the systolic-array drain path.
//   ctrl_t        : controller command (drain_en + tile base address c_addr)
//   drain_data_t  : one drain beat (enable + element data)
//   row_t         : one tile row, element col at bits [col*DATA_WIDTH +: DATA_WIDTH]
//   drain_state_t : drain collector FSM states
package common_pkg;

    localparam int unsigned SYS_ARRAY_SIZE     = 4;
    localparam int unsigned DATA_WIDTH         = 8;
    localparam int unsigned ADDR_WIDTH         = 64;
    localparam int unsigned DRAIN_CHANNEL_SIZE = (SYS_ARRAY_SIZE + 1) / 2;
    localparam int unsigned T_D                = 2 * SYS_ARRAY_SIZE;
    localparam int unsigned BEAT_CNT_W         = $clog2(T_D) + 1;
    localparam int unsigned IDX_W              = (SYS_ARRAY_SIZE > 1) ? $clog2(SYS_ARRAY_SIZE) : 1;

    typedef logic [$clog2(SYS_ARRAY_SIZE + 1)-1:0] mcount_t;

    typedef struct packed {
        logic                  drain_en;
        logic [ADDR_WIDTH-1:0] c_addr;
    } ctrl_t;

    typedef struct packed {
        logic                  enable;
        logic [DATA_WIDTH-1:0] data;
    } drain_data_t;

    typedef logic [SYS_ARRAY_SIZE*DATA_WIDTH-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } drain_state_t;

    // The last channel carries a single row when the array size is odd.
    function automatic int unsigned expected_beats(input int unsigned ch);
        if ((SYS_ARRAY_SIZE % 2 == 1) && (ch == DRAIN_CHANNEL_SIZE - 1)) begin
            return SYS_ARRAY_SIZE;
        end
        return T_D;
    endfunction

endpackage

// File: rtl/drain_channel_rx.sv
// Per-channel drain receiver: counts accepted beats, maps the current beat to
// its (row, col) position in the tile and raises the buffer write enable.
//   clk, rst_n  : clock, async active-low reset
//   clear       : zero the beat counter (new tile accepted)
//   active      : collector is in COLLECT; beats outside it are ignored
//   beat        : incoming drain beat
//   wr_en_c     : buffer write enable for this cycle's beat
//   wr_row_c    : tile row of this cycle's beat
//   wr_col_c    : tile column of this cycle's beat
//   wr_data_c   : element value to write
//   complete_c  : channel has all its beats, counting a completing beat this cycle
module drain_channel_rx
    import common_pkg::*;
#(
    parameter int unsigned CH = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  active,
    input  drain_data_t           beat,
    output logic                  wr_en_c,
    output logic [IDX_W-1:0]      wr_row_c,
    output logic [IDX_W-1:0]      wr_col_c,
    output logic [DATA_WIDTH-1:0] wr_data_c,
    output logic                  complete_c
);

    localparam int unsigned EXP_BEATS = expected_beats(CH);

    logic [BEAT_CNT_W-1:0] count_q;
    logic                  full_c;

    // Beat b lands at row 2*CH + b/N, col b%N; beats past the expected count drop.
    always_comb begin
        full_c     = (count_q == BEAT_CNT_W'(EXP_BEATS));
        wr_en_c    = active && beat.enable && !full_c;
        wr_row_c   = IDX_W'(2 * CH + 32'(count_q) / SYS_ARRAY_SIZE);
        wr_col_c   = IDX_W'(32'(count_q) % SYS_ARRAY_SIZE);
        wr_data_c  = beat.data;
        complete_c = full_c || (wr_en_c && (count_q == BEAT_CNT_W'(EXP_BEATS - 1)));
    end

    // Beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (wr_en_c) begin
            count_q <= count_q + BEAT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/drain_collector.sv
// Drain collector: gathers the N x N result tile from the drain channels into a
// local buffer, then writes it to memory one row per request starting at c_addr.
//   clk, rst_n   : clock, async active-low reset
//   ctrl_i       : command; drain_en starts a tile, c_addr is its base address
//   drain_i      : drain channels, beat valid when enable=1
//   mem_req_o    : row write request
//   mem_addr_o   : row write address (c_addr + r*N, wrapping)
//   mem_wdata_o  : row data, element col at [col*DATA_WIDTH +: DATA_WIDTH]
//   mem_gnt_i    : grant, request completes when req & gnt
//   busy_o       : tile in progress
//   done_o       : one-cycle pulse after the last row is granted
module drain_collector
    import common_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  ctrl_t                                ctrl_i,
    input  drain_data_t [DRAIN_CHANNEL_SIZE-1:0] drain_i,
    output logic                                 mem_req_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output row_t                                 mem_wdata_o,
    input  logic                                 mem_gnt_i,
    output logic                                 busy_o,
    output logic                                 done_o
);

    localparam int unsigned N   = SYS_ARRAY_SIZE;
    localparam int unsigned DCS = DRAIN_CHANNEL_SIZE;

    drain_state_t          state_q;
    logic [ADDR_WIDTH-1:0] c_addr_q;
    mcount_t               row_q;
    mcount_t               next_row_c;
    row_t                  buf_q [N];
    row_t                  row0_view_c;

    logic                  clear_c;
    logic                  active_c;
    logic                  all_complete_c;
    logic [DCS-1:0]        ch_wr_en_c;
    logic [DCS-1:0]        ch_complete_c;
    logic [IDX_W-1:0]      ch_row_c  [DCS];
    logic [IDX_W-1:0]      ch_col_c  [DCS];
    logic [DATA_WIDTH-1:0] ch_data_c [DCS];

    always_comb begin
        clear_c        = (state_q == IDLE) && ctrl_i.drain_en;
        active_c       = (state_q == COLLECT);
        all_complete_c = &ch_complete_c;
        next_row_c     = mcount_t'(row_q + mcount_t'(1));
    end

    for (genvar g = 0; g < DCS; g++) begin : g_rx
        drain_channel_rx #(
            .CH(g)
        ) u_rx (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (clear_c),
            .active     (active_c),
            .beat       (drain_i[g]),
            .wr_en_c    (ch_wr_en_c[g]),
            .wr_row_c   (ch_row_c[g]),
            .wr_col_c   (ch_col_c[g]),
            .wr_data_c  (ch_data_c[g]),
            .complete_c (ch_complete_c[g])
        );
    end

    // Tile buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < DCS; ch++) begin
            if (ch_wr_en_c[ch]) begin
                buf_q[ch_row_c[ch]][ch_col_c[ch]*DATA_WIDTH +: DATA_WIDTH] <= ch_data_c[ch];
            end
        end
    end

    // Row 0 as it will look after this cycle's writes, so the first request
    // can be registered in the same cycle the final beat arrives.
    always_comb begin
        row0_view_c = buf_q[0];
        for (int ch = 0; ch < DCS; ch++) begin
            if (ch_wr_en_c[ch] && (ch_row_c[ch] == IDX_W'(0))) begin
                row0_view_c[ch_col_c[ch]*DATA_WIDTH +: DATA_WIDTH] = ch_data_c[ch];
            end
        end
    end

    // Control FSM with registered memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            c_addr_q    <= '0;
            row_q       <= '0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ctrl_i.drain_en) begin
                        c_addr_q <= ctrl_i.c_addr;
                        busy_o   <= 1'b1;
                        state_q  <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (all_complete_c) begin
                        row_q       <= '0;
                        mem_req_o   <= 1'b1;
                        mem_addr_o  <= c_addr_q;
                        mem_wdata_o <= row0_view_c;
                        state_q     <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_req_o && mem_gnt_i) begin
                        if (row_q == mcount_t'(N - 1)) begin
                            mem_req_o <= 1'b0;
                            busy_o    <= 1'b0;
                            done_o    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            row_q       <= next_row_c;
                            mem_addr_o  <= mem_addr_o + ADDR_WIDTH'(N);
                            mem_wdata_o <= buf_q[IDX_W'(next_row_c)];
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
